axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameters SHALL be as follows, one per line.
- ADDR_W, 64, address width.
- DATA_W, 64, read data width.
REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_arvalid  in  1  instruction-cache read request.
- i_araddr  in  ADDR_W  instruction-cache request address.
- i_arlen / i_arsize / i_arburst  in  8/3/2  instruction-cache burst attributes.
- i_arready  out  1  instruction-cache request accepted (one-cycle pulse).
- i_rvalid / i_rlast  out  1/1  instruction-cache read beat / last beat.
- i_rdata  out  DATA_W  instruction-cache read data.
- i_rready  in  1  instruction cache accepts beat.
- i_flush  in  1  discard the remainder of the instruction-cache burst (jump/redirect).
- d_arvalid  in  1  data-cache read request.
- d_araddr  in  ADDR_W  data-cache request address.
- d_arlen / d_arsize / d_arburst  in  8/3/2  data-cache burst attributes.
- d_arready  out  1  data-cache request accepted (one-cycle pulse).
- d_rvalid / d_rlast  out  1/1  data-cache read beat / last beat.
- d_rdata  out  DATA_W  data-cache read data.
- d_rready  in  1  data cache accepts beat.
- m_axi_arvalid  out  1  shared AR valid.
- m_axi_araddr  out  ADDR_W  shared AR address.
- m_axi_arlen / m_axi_arsize / m_axi_arburst  out  8/3/2  shared AR burst attributes.
- m_axi_arready  in  1  AR accepted by memory.
- m_axi_rvalid / m_axi_rlast  in  1/1  shared R beat / last beat.
- m_axi_rdata  in  DATA_W  shared R data.
- m_axi_rready  out  1  shared R ready.
- i_busy / d_busy  out  1/1  owner is mid-transaction (instruction_cache_reading / data_cache_reading).

Function
REQ-003 FSM states SHALL be IDLE, ADDR, DATA; a registered owner bit (I or D) is qualified by state.
REQ-004 In IDLE, if exactly one requester has arvalid=1, that requester SHALL be granted.
REQ-005 In IDLE, if both requesters have arvalid=1, the requester not granted last SHALL win (round-robin); last_grant resets to D, so I wins the first tie.
REQ-006 On grant (IDLE, cycle N), the grantee's arready SHALL pulse high for cycle N only.
- araddr/arlen/arsize/arburst SHALL be captured into registers in cycle N.
- Owner and last_grant SHALL update in cycle N.
- State SHALL move to ADDR.
REQ-007 In ADDR, m_axi_arvalid SHALL be 1 and the m_axi_ar* fields SHALL drive the captured values.
- The fields SHALL be held stable until m_axi_arready=1.
- On m_axi_arready=1, state SHALL move to DATA.
- First m_axi_arvalid cycle is N+1.
REQ-008 m_axi_arvalid SHALL be 0 in every state other than ADDR.
REQ-009 In DATA, m_axi_rdata/rvalid/rlast SHALL route to the owner's r* outputs, and m_axi_rready SHALL equal the owner's rready.
- The non-owner's rvalid SHALL be 0; its arready SHALL be 0 outside the grant pulse.
REQ-010 Handshake m_axi_rvalid&m_axi_rready&m_axi_rlast SHALL return state to IDLE next cycle.
- A new grant is therefore earliest one cycle after the last beat.
REQ-011 i_flush=1 while owner=I in ADDR or DATA SHALL set a sticky drop flag.
- The AR handshake SHALL still complete.
- With drop set, m_axi_rready SHALL be 1 and i_rvalid SHALL be 0.
- Beats SHALL be consumed until rlast; then return to IDLE and clear drop.
- i_flush while owner=D or in IDLE SHALL have no effect.
REQ-012 i_busy SHALL be 1 in ADDR/DATA with owner=I; d_busy SHALL be 1 in ADDR/DATA with owner=D.
REQ-013 Requester arvalid deassertion after grant SHALL NOT affect the in-flight transaction.
REQ-014 rlast SHALL be the only burst terminator; no beat counting against arlen.

Reset
REQ-015 On reset, state SHALL be IDLE, owner=I, last_grant=D, and drop=0.
- All valid/ready/busy outputs SHALL be 0; captured AR registers SHALL be 0.
REQ-016 reset mid-transaction SHALL abandon it immediately; the memory model is reset together with this block.

Verification
REQ-017 Benches SHALL cover:
- Single I request, addr 0x1000, arlen 7, memory arready delayed 3 cycles -> i_arready pulse at N; m_axi_arvalid N+1..N+4 with stable fields; 8 beats to I; IDLE after rlast.
- I and D requesting same cycle from reset -> I granted first; D granted the cycle after I's IDLE return; next tie goes to I.
- D owns with backpressure (d_rready toggling) -> m_axi_rready mirrors d_rready; i_rvalid stays 0; no beat lost or duplicated.
- i_flush on second beat of 8-beat I burst -> beats 3..8 consumed with m_axi_rready=1 and i_rvalid=0; then IDLE; pending D granted next.
- i_flush during D ownership -> no change to D data or m_axi_rready.
- reset asserted during DATA -> all outputs 0 next cycle; fresh request granted normally afterwards.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read channel between I$ and D$.
// Round-robin on ties; i_flush drains an abandoned I$ burst.
module axi_read_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_arvalid,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [7:0]        i_arlen,
  input  logic [2:0]        i_arsize,
  input  logic [1:0]        i_arburst,
  output logic              i_arready,
  output logic              i_rvalid,
  output logic              i_rlast,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              i_rready,
  input  logic              i_flush,
  input  logic              d_arvalid,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [7:0]        d_arlen,
  input  logic [2:0]        d_arsize,
  input  logic [1:0]        d_arburst,
  output logic              d_arready,
  output logic              d_rvalid,
  output logic              d_rlast,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              d_rready,
  output logic              m_axi_arvalid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  input  logic              m_axi_arready,
  input  logic              m_axi_rvalid,
  input  logic              m_axi_rlast,
  input  logic [DATA_W-1:0] m_axi_rdata,
  output logic              m_axi_rready,
  output logic              i_busy,
  output logic              d_busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state;
  logic              owner_d;
  logic              last_d;
  logic              drop;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;

  logic grant;
  logic pick_d;
  logic in_data;
  logic to_i;
  logic to_d;
  logic last_beat;

  // pick_d: D wins alone, or on a tie when I was granted last
  always_comb begin
    grant  = (state == IDLE) && (i_arvalid || d_arvalid);
    pick_d = d_arvalid && (!i_arvalid || !last_d);
  end

  assign i_arready = grant && !pick_d;
  assign d_arready = grant && pick_d;

  assign in_data = (state == DATA);
  assign to_i    = in_data && !owner_d && !drop;
  assign to_d    = in_data && owner_d;

  assign i_busy = (state != IDLE) && !owner_d;
  assign d_busy = (state != IDLE) && owner_d;

  assign m_axi_arvalid = (state == ADDR);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = burst_q;

  assign m_axi_rready = in_data &&
                        (owner_d ? d_rready : (drop || i_rready));

  assign i_rvalid = to_i && m_axi_rvalid;
  assign i_rlast  = to_i && m_axi_rlast;
  assign i_rdata  = m_axi_rdata;
  assign d_rvalid = to_d && m_axi_rvalid;
  assign d_rlast  = to_d && m_axi_rlast;
  assign d_rdata  = m_axi_rdata;

  assign last_beat = in_data && m_axi_rvalid &&
                     m_axi_rready && m_axi_rlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      last_d  <= 1'b1;
      drop    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            state   <= ADDR;
            owner_d <= pick_d;
            last_d  <= pick_d;
            if (pick_d) begin
              addr_q  <= d_araddr;
              len_q   <= d_arlen;
              size_q  <= d_arsize;
              burst_q <= d_arburst;
            end else begin
              addr_q  <= i_araddr;
              len_q   <= i_arlen;
              size_q  <= i_arsize;
              burst_q <= i_arburst;
            end
          end
        end
        ADDR: begin
          if (m_axi_arready) state <= DATA;
        end
        DATA: begin
          if (last_beat) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (last_beat) drop <= 1'b0;
      else if (i_busy && i_flush) drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: scoreboard bench with a behavioural memory
// and a round-robin reference model for the arbiter.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_arvalid, d_arvalid;
  logic [63:0] i_araddr, d_araddr;
  logic [7:0]  i_arlen, d_arlen;
  logic [2:0]  i_arsize, d_arsize;
  logic [1:0]  i_arburst, d_arburst;
  logic        i_arready, d_arready;
  logic        i_rvalid, i_rlast, d_rvalid, d_rlast;
  logic [63:0] i_rdata, d_rdata;
  logic        i_rready, d_rready, i_flush;
  logic        m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic [63:0] m_axi_rdata;
  logic        i_busy, d_busy;

  axi_read_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen),
    .i_arsize(i_arsize), .i_arburst(i_arburst), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rdata(i_rdata),
    .i_rready(i_rready), .i_flush(i_flush),
    .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen),
    .d_arsize(d_arsize), .d_arburst(d_arburst), .d_arready(d_arready),
    .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rdata(d_rdata),
    .d_rready(d_rready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
    .m_axi_rdata(m_axi_rdata), .m_axi_rready(m_axi_rready),
    .i_busy(i_busy), .d_busy(d_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [63:0] data_of(input logic [63:0] a, input int b);
    return {a[47:0], b[7:0], 8'h5a};
  endfunction

  // negedge samples shared with the memory model
  bit          s_arv, s_rr, s_rst;
  logic [63:0] s_addr;
  logic [7:0]  s_len;

  // behavioural memory
  int          ar_delay = 0;
  bit          ar_rand = 0;
  int          rv_pct = 100;
  int          ar_wait = 0;
  bit          m_phase = 0;
  logic [63:0] m_addr;
  int          m_len, m_beat;

  initial begin
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = 0;
    forever begin
      @(posedge clk); #1;
      if (s_rst) begin
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
        m_phase = 0; ar_wait = 0;
        continue;
      end
      if (!m_phase) begin
        if (m_axi_arready && s_arv) begin
          m_axi_arready = 0; m_addr = s_addr; m_len = int'(s_len);
          m_beat = 0; m_phase = 1; ar_wait = 0;
          if (ar_rand) ar_delay = $urandom_range(3);
        end else if (m_axi_arvalid) begin
          if (ar_wait >= ar_delay) m_axi_arready = 1;
          else ar_wait++;
        end
      end
      if (m_phase) begin
        if (m_axi_rvalid && s_rr) begin
          m_beat++;
          m_axi_rvalid = 0;
          if (m_axi_rlast) begin m_phase = 0; m_axi_rlast = 0; end
        end
        if (m_phase && !m_axi_rvalid && $urandom_range(99) < rv_pct) begin
          m_axi_rvalid = 1;
          m_axi_rdata  = data_of(m_addr, m_beat);
          m_axi_rlast  = (m_beat == m_len);
        end
      end
    end
  end

  // consumers
  bit i_rr_rand = 0, d_rr_rand = 0;
  initial begin
    i_rready = 1; d_rready = 1;
    forever begin
      @(posedge clk); #1;
      i_rready = i_rr_rand ? 1'($urandom_range(1)) : 1'b1;
      d_rready = d_rr_rand ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // scoreboard and reference model
  logic [63:0] i_q[$], d_q[$];
  bit          glog[$];
  bit          model_last_d = 1;
  bit          expect_drop = 0;
  int          i_beats, d_beats, drop_beats, i_grants;
  int          grant_cyc_i, grant_cyc_d, last_rlast_i;
  int          ar_first, ar_n;
  logic [63:0] exp_addr;
  logic [7:0]  exp_len;
  logic [2:0]  exp_size;
  logic [1:0]  exp_burst;

  initial begin
    logic [63:0] e;
    bit w;
    forever begin
      @(negedge clk);
      s_arv = m_axi_arvalid; s_rr = m_axi_rready; s_rst = reset;
      s_addr = m_axi_araddr; s_len = m_axi_arlen;
      if (reset) begin
        model_last_d = 1; i_q.delete(); d_q.delete();
        continue;
      end
      if (i_arready || d_arready) begin
        w = (i_arvalid && d_arvalid) ? !model_last_d : d_arvalid;
        chk(i_arready == !w && d_arready == w, "grant_winner",
            {62'd0, d_arready, i_arready}, {62'd0, w, !w});
        model_last_d = w;
        glog.push_back(w);
        ar_n = 0;
        exp_addr  = w ? d_araddr : i_araddr;
        exp_len   = w ? d_arlen : i_arlen;
        exp_size  = w ? d_arsize : i_arsize;
        exp_burst = w ? d_arburst : i_arburst;
        if (w) grant_cyc_d = cyc;
        else begin grant_cyc_i = cyc; i_grants++; end
        for (int b = 0; b <= int'(exp_len); b++) begin
          if (w) d_q.push_back(data_of(exp_addr, b));
          else i_q.push_back(data_of(exp_addr, b));
        end
      end
      if (m_axi_arvalid) begin
        if (ar_n == 0) ar_first = cyc;
        ar_n++;
        chk(m_axi_araddr == exp_addr && m_axi_arlen == exp_len &&
            m_axi_arsize == exp_size && m_axi_arburst == exp_burst,
            "ar_fields", m_axi_araddr, exp_addr);
      end
      if (i_rvalid && i_rready) begin
        if (i_q.size() == 0) chk(0, "i_unexpected_beat", i_rdata, 0);
        else begin
          e = i_q.pop_front();
          chk(i_rdata == e, "i_rdata", i_rdata, e);
          chk(i_rlast == (i_q.size() == 0), "i_rlast", 64'(i_rlast),
              64'(i_q.size() == 0));
          i_beats++;
          if (i_rlast) last_rlast_i = cyc;
        end
      end
      if (d_rvalid && d_rready) begin
        if (d_q.size() == 0) chk(0, "d_unexpected_beat", d_rdata, 0);
        else begin
          e = d_q.pop_front();
          chk(d_rdata == e, "d_rdata", d_rdata, e);
          chk(d_rlast == (d_q.size() == 0), "d_rlast", 64'(d_rlast),
              64'(d_q.size() == 0));
          d_beats++;
        end
      end
      if (d_busy && !m_axi_arvalid)
        chk(m_axi_rready == d_rready && !i_rvalid, "d_own_rready",
            {62'd0, i_rvalid, m_axi_rready}, {63'd0, d_rready});
      if (expect_drop && i_busy && m_axi_rvalid) begin
        chk(m_axi_rready && !i_rvalid, "drop_consume",
            {62'd0, i_rvalid, m_axi_rready}, 64'd1);
        if (m_axi_rready) drop_beats++;
      end
      if (i_busy && d_busy) chk(0, "both_busy", 64'd3, 64'd0);
    end
  end

  task automatic issue(input bit is_d, input logic [63:0] a,
                       input logic [7:0] len);
    bit got = 0;
    @(posedge clk); #1;
    if (is_d) begin
      d_arvalid = 1; d_araddr = a; d_arlen = len;
      d_arsize = len[2:0]; d_arburst = 2'(len >> 3);
    end else begin
      i_arvalid = 1; i_araddr = a; i_arlen = len;
      i_arsize = ~len[2:0]; i_arburst = 2'(len >> 2);
    end
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      got = is_d ? d_arready : i_arready;
    end
    if (!got) chk(0, is_d ? "d_grant_timeout" : "i_grant_timeout", 0, 1);
    @(posedge clk); #1;
    if (is_d) d_arvalid = 0;
    else i_arvalid = 0;
  endtask

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int k = 0; k < 5000 && !done; k++) begin
      @(negedge clk);
      done = !i_busy && !d_busy && !i_arvalid && !d_arvalid &&
             i_q.size() == 0 && d_q.size() == 0;
    end
    chk(done, nm, {62'd0, d_busy, i_busy}, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; i_arvalid = 0; d_arvalid = 0; i_flush = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    glog.delete();
    i_beats = 0; d_beats = 0; drop_beats = 0; i_grants = 0;
  endtask

  task automatic rnd_requester(input bit is_d, input int n, output int beats);
    logic [7:0] len;
    beats = 0;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(3)) @(posedge clk);
      len = 8'($urandom_range(5));
      beats += int'(len) + 1;
      issue(is_d, {32'd0, $urandom} & ~64'h7, len);
    end
  endtask

  initial begin
    int   ei, ed;
    int   gd1, lr1;
    bit   ok;
    reset = 1; i_arvalid = 0; d_arvalid = 0; i_flush = 0;
    i_araddr = 0; i_arlen = 0; i_arsize = 0; i_arburst = 0;
    d_araddr = 0; d_arlen = 0; d_arsize = 0; d_arburst = 0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({i_arready, d_arready, i_rvalid, d_rvalid, m_axi_arvalid,
         m_axi_rready, i_busy, d_busy} == 8'h00, "reset_outputs",
        {56'd0, i_arready, d_arready, i_rvalid, d_rvalid, m_axi_arvalid,
         m_axi_rready, i_busy, d_busy}, 0);
    chk(m_axi_araddr == 0 && m_axi_arlen == 0 && m_axi_arsize == 0 &&
        m_axi_arburst == 0, "reset_ar_regs", m_axi_araddr, 0);
    #1 reset = 0;
    i_beats = 0; d_beats = 0; i_grants = 0;

    // single I request, memory arready after 3 cycles
    ar_delay = 3;
    issue(0, 64'h1000, 8'd7);
    wait_idle("single_idle");
    chk(ar_first == grant_cyc_i + 1, "ar_first_cycle", 64'(ar_first),
        64'(grant_cyc_i + 1));
    chk(ar_n == 4, "ar_valid_cycles", 64'(ar_n), 4);
    chk(i_beats == 8, "single_beats", 64'(i_beats), 8);
    chk(i_grants == 1, "single_arready_pulses", 64'(i_grants), 1);

    // tie from reset: I, then D right after I returns, then I again
    do_reset();
    ar_delay = 0; rv_pct = 70;
    fork
      issue(0, 64'h2000, 8'd3);
      issue(1, 64'h3000, 8'd2);
    join
    wait_idle("tie1_idle");
    gd1 = grant_cyc_d; lr1 = last_rlast_i;
    chk(gd1 == lr1 + 1, "d_grant_after_i", 64'(gd1), 64'(lr1 + 1));
    fork
      issue(0, 64'h4000, 8'd1);
      issue(1, 64'h5000, 8'd1);
    join
    wait_idle("tie2_idle");
    ok = glog.size() == 4;
    chk(ok && glog[0] == 0 && glog[1] == 1 && glog[2] == 0 && glog[3] == 1,
        "tie_order", 64'(glog.size()), 4);

    // D with backpressure
    do_reset();
    d_rr_rand = 1; ar_delay = 2; rv_pct = 60;
    issue(1, 64'h8000, 8'd9);
    wait_idle("d_bp_idle");
    chk(d_beats == 10, "d_bp_beats", 64'(d_beats), 10);
    d_rr_rand = 0;

    // flush on second beat of an 8-beat I burst, D pending
    do_reset();
    rv_pct = 100; ar_delay = 1;
    fork
      issue(0, 64'h9000, 8'd7);
      begin repeat (3) @(posedge clk); issue(1, 64'hA000, 8'd3); end
    join_none
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (i_beats >= 1) break;
    end
    i_flush = 1;
    @(posedge clk); #1;
    i_flush = 0; i_q.delete(); expect_drop = 1;
    for (int k = 0; k < 500 && i_busy; k++) @(negedge clk);
    expect_drop = 0;
    wait_idle("flush_idle");
    chk(i_beats == 2, "flush_i_beats", 64'(i_beats), 2);
    chk(drop_beats == 6, "flush_dropped", 64'(drop_beats), 6);
    chk(d_beats == 4, "flush_d_beats", 64'(d_beats), 4);
    chk(glog.size() == 2 && glog[glog.size()-1] == 1, "flush_then_d",
        64'(glog.size()), 2);

    // flush while D owns has no effect
    do_reset();
    d_rr_rand = 1; rv_pct = 80;
    fork
      issue(1, 64'hB000, 8'd7);
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1 i_flush = 1'($urandom_range(1));
      end
    join
    i_flush = 0;
    wait_idle("dflush_idle");
    chk(d_beats == 8, "dflush_d_beats", 64'(d_beats), 8);
    d_rr_rand = 0;
    issue(0, 64'hC000, 8'd3);
    wait_idle("dflush_i_idle");
    chk(i_beats == 4, "dflush_i_beats", 64'(i_beats), 4);

    // reset in the middle of DATA
    do_reset();
    rv_pct = 100; ar_delay = 0;
    issue(0, 64'hD000, 8'd7);
    for (int k = 0; k < 500 && i_beats < 2; k++) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk({i_arready, d_arready, i_rvalid, d_rvalid, m_axi_arvalid,
         m_axi_rready, i_busy, d_busy} == 8'h00, "midreset_outputs",
        {56'd0, i_arready, d_arready, i_rvalid, d_rvalid, m_axi_arvalid,
         m_axi_rready, i_busy, d_busy}, 0);
    @(posedge clk); #1 reset = 0;
    d_beats = 0;
    issue(1, 64'hE000, 8'd2);
    wait_idle("postreset_idle");
    chk(d_beats == 3, "postreset_d_beats", 64'(d_beats), 3);

    // randomized contention
    do_reset();
    i_rr_rand = 1; d_rr_rand = 1; rv_pct = 60; ar_rand = 1;
    fork
      rnd_requester(0, 15, ei);
      rnd_requester(1, 15, ed);
    join
    wait_idle("random_idle");
    chk(i_beats == ei, "random_i_beats", 64'(i_beats), 64'(ei));
    chk(d_beats == ed, "random_d_beats", 64'(d_beats), 64'(ed));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
